jtag_debug_sysclk_decoder: RTL and testbench
============================================

# jtag_debug_sysclk_decoder

Parametrised system-clock half of the on-chip debug JTAG path: takes the virtual-JTAG update strobes, IR code and scanned data register from the TCK domain, synchronises the strobes into `clk`, and emits the captured data word plus one-hot per-command action pulses. It generalises the fixed 2-bit-IR, 38-bit-DR decoder to arbitrary IR/DR widths and synchronizer depth. It adds an optional valid/ready command handshake with overrun detection for multi-cycle consumers.

## Interface
- `IR_W`, default 2: IR code width; command count `NCMD = 2**IR_W`.
- `DR_W`, default 38: scanned data register width.
- `ACT_BIT`, default `DR_W-1`: data bit that selects action (1) vs no-action (0).
- `SYNC_STAGES`, default 2 (min 2): synchronizer flops per strobe.

Ports:
- `clk`  in  1  system clock; single clock domain for all state.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ir_in`  in  IR_W  TCK-domain IR code, stable while `vs_uir` is high.
- `sr`  in  DR_W  TCK-domain shift register, stable from `vs_udr` rise until the next shift.
- `vs_uir`  in  1  TCK-domain update-IR level; asynchronous to `clk`.
- `vs_udr`  in  1  TCK-domain update-DR level; asynchronous to `clk`.
- `jdo`  out  DR_W  captured data word.
- `cmd_ir`  out  IR_W  IR code associated with `jdo`.
- `take_action`  out  NCMD  one-hot single-cycle pulse, index = command IR.
- `take_no_action`  out  NCMD  one-hot single-cycle pulse, index = command IR.
- `cmd_valid`  out  1  command held for the consumer.
- `cmd_ready`  in  1  consumer accepts the command.
- `ovr_clr`  in  1  clears `overrun`.
- `overrun`  out  1  sticky flag: an update arrived while a command was still held.

## Operation
- Each strobe passes through a `SYNC_STAGES` flop chain, then a prev-value register.
  - An event is the synced value at 1 with prev at 0.
  - Events are armed only after the synced value has been seen at 0 at least once since reset, so a strobe held high through reset release produces no event.
- UIR event: `ir_q <= ir_in`.
- UDR event:
  - Decode IR = `ir_in` if a UIR event occurs in the same cycle, else `ir_q`.
  - If accepted: `jdo <= sr`, `cmd_ir <=` decode IR.
  - If accepted: the pulse goes to bit [decode IR] of `take_action` if `sr[ACT_BIT]` is 1, else of `take_no_action`. All other bits stay 0.
  - Pulses deassert on the next edge; at most one bit across both vectors is high at any time.
- Acceptance rule: see Configuration. Without handshake, every UDR event is accepted.
- Width rules:
  - `jdo` is a full-width copy of `sr`; no truncation.
  - `ACT_BIT` must be `< DR_W`; the bench asserts this at elaboration.

## Timing
- Reset values: `jdo`=0, `cmd_ir`=0, `ir_q`=0, `take_action`=0, `take_no_action`=0, `cmd_valid`=0, `overrun`=0; synchronizers, prev registers and arm flags = 0.
- Latency: `vs_udr` rise to `jdo` update and pulse = `SYNC_STAGES`+1 `clk` edges (3 at default). UIR path has the same latency.
- Minimum `vs_udr` low and high times: `SYNC_STAGES`+1 `clk` periods each; shorter strobes may be missed.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending pulse is lost; no pulse is emitted on release.

## Configuration
- Macro: `JTAG_DBG_CMD_HS_EN`.
- Defined:
  - A UDR event is accepted if `cmd_valid`=0, or if `cmd_valid`=1 and `cmd_ready`=1 in the same cycle.
  - Acceptance sets `cmd_valid`=1.
  - `cmd_valid` drops on the edge where `cmd_ready`=1 and no new event is accepted.
  - A UDR event with `cmd_valid`=1 and `cmd_ready`=0 is dropped: `jdo`/`cmd_ir` unchanged, no pulse, `overrun<=1`.
  - `ovr_clr` clears `overrun`; a simultaneous set wins.
- Not defined:
  - Every event is accepted.
  - `cmd_valid` and `overrun` are constant 0.
  - `cmd_ready` and `ovr_clr` are ignored.

## Test plan
- Reset, IR_W=2: `ir_in`=2'b01 with `vs_uir` pulse, then `sr`=38'h20_0000_1234 with `vs_udr` pulse -> 3 edges after the UDR rise, `jdo`=38'h20_0000_1234, `take_action`=4'b0010 for exactly 1 cycle, `take_no_action`=0.
- Same sequence with `sr[37]`=0 -> `take_no_action`=4'b0010 pulse; `take_action` stays 0.
- `vs_udr` held high across reset release -> no pulse; after low then high, exactly one pulse.
- `vs_uir` and `vs_udr` rise in the same `clk` cycle with `ir_in`=2'b11 (prior `ir_q`=2'b00) -> pulse on bit 3, `cmd_ir`=2'b11.
- `JTAG_DBG_CMD_HS_EN`, `cmd_ready`=0, two UDR events with `sr`=A then B:
  - `jdo`=A, `cmd_valid`=1, `overrun`=1, one pulse total.
  - `cmd_ready`=1 -> `cmd_valid`=0 next edge; `ovr_clr` -> `overrun`=0.
- DR_W=64, IR_W=3, SYNC_STAGES=3: `sr`=64'h8000_0000_DEAD_BEEF, IR=5 -> `jdo` matches at 4 edges, `take_action`=8'b0010_0000.

Source files
------------

// File: rtl/jtag_debug_sysclk_decoder.sv
// System-clock half of the debug JTAG path: synchronises update-IR/DR strobes and decodes one-hot action pulses.
// Optional valid/ready command handshake with overrun detection: define JTAG_DBG_CMD_HS_EN.
module jtag_debug_sysclk_decoder #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int ACT_BIT     = DR_W - 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DR_W-1:0]      sr,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    output logic [DR_W-1:0]      jdo,
    output logic [IR_W-1:0]      cmd_ir,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    input  logic                 ovr_clr,
    output logic                 overrun
);

    localparam int NCMD = 2**IR_W;

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   uir_prev;
    logic                   udr_prev;
    logic                   uir_arm;
    logic                   udr_arm;
    logic                   uir_s;
    logic                   udr_s;
    logic                   uir_evt;
    logic                   udr_evt;
    logic                   accept;
    logic [IR_W-1:0]        ir_q;
    logic [IR_W-1:0]        dec_ir;
    logic [NCMD-1:0]        cmd_oh;

    assign uir_s = uir_sync[SYNC_STAGES-1];
    assign udr_s = udr_sync[SYNC_STAGES-1];

    // fill marks when the synchronizer tail holds a real sample rather than reset zeros,
    // so a strobe held high through reset release never looks like a fresh rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
            fill     <= '0;
            uir_prev <= 1'b0;
            udr_prev <= 1'b0;
            uir_arm  <= 1'b0;
            udr_arm  <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            uir_prev <= uir_s;
            udr_prev <= udr_s;
            if (fill[SYNC_STAGES-1] && !uir_s) uir_arm <= 1'b1;
            if (fill[SYNC_STAGES-1] && !udr_s) udr_arm <= 1'b1;
        end
    end

    assign uir_evt = uir_s & ~uir_prev & uir_arm;
    assign udr_evt = udr_s & ~udr_prev & udr_arm;
    assign dec_ir  = uir_evt ? ir_in : ir_q;
    assign cmd_oh  = NCMD'(1) << dec_ir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q           <= '0;
            jdo            <= '0;
            cmd_ir         <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (uir_evt) ir_q <= ir_in;
            if (accept) begin
                jdo    <= sr;
                cmd_ir <= dec_ir;
                if (sr[ACT_BIT]) take_action    <= cmd_oh;
                else             take_no_action <= cmd_oh;
            end
        end
    end

`ifdef JTAG_DBG_CMD_HS_EN
    assign accept = udr_evt & (~cmd_valid | cmd_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept)         cmd_valid <= 1'b1;
            else if (cmd_ready) cmd_valid <= 1'b0;
            // a dropped update outranks a simultaneous clear
            if (udr_evt && cmd_valid && !cmd_ready) overrun <= 1'b1;
            else if (ovr_clr)                        overrun <= 1'b0;
        end
    end
`else
    logic unused_hs;

    assign accept    = udr_evt;
    assign cmd_valid = 1'b0;
    assign overrun   = 1'b0;
    assign unused_hs = cmd_ready ^ ovr_clr;
`endif

endmodule

// File: tb/tb_jtag_debug_sysclk_decoder.sv
// Bench for jtag_debug_sysclk_decoder: default-width and 64-bit/3-stage instances, scoreboarded pulses.
module tb_jtag_debug_sysclk_decoder;

    localparam int D0_IR = 2, D0_DR = 38, D0_ACT = 37, D0_SS = 2;
    localparam int D1_IR = 3, D1_DR = 64, D1_ACT = 63, D1_SS = 3;

    typedef struct {
        int unsigned  cyc;
        logic [63:0]  jdo;
        logic [2:0]   ir;
        logic [7:0]   ta;
        logic [7:0]   tna;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic [D0_IR-1:0] ir0;
    logic [D0_DR-1:0] sr0, jdo0;
    logic [D0_IR-1:0] cmdir0;
    logic [3:0]       ta0, tna0;
    logic             uir0, udr0, cv0, rdy0, clr0, ovr0;

    logic [D1_IR-1:0] ir1;
    logic [D1_DR-1:0] sr1, jdo1;
    logic [D1_IR-1:0] cmdir1;
    logic [7:0]       ta1, tna1;
    logic             uir1, udr1, cv1, rdy1, clr1, ovr1;

    if (D0_ACT >= D0_DR || D1_ACT >= D1_DR) begin : g_act_bit_bad
        initial $fatal(1, "FAIL act_bit_range ACT_BIT must be below DR_W");
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtag_debug_sysclk_decoder #(
        .IR_W(D0_IR), .DR_W(D0_DR), .ACT_BIT(D0_ACT), .SYNC_STAGES(D0_SS)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .ir_in(ir0), .sr(sr0),
        .vs_uir(uir0), .vs_udr(udr0), .jdo(jdo0), .cmd_ir(cmdir0),
        .take_action(ta0), .take_no_action(tna0), .cmd_valid(cv0),
        .cmd_ready(rdy0), .ovr_clr(clr0), .overrun(ovr0)
    );

    jtag_debug_sysclk_decoder #(
        .IR_W(D1_IR), .DR_W(D1_DR), .SYNC_STAGES(D1_SS)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .ir_in(ir1), .sr(sr1),
        .vs_uir(uir1), .vs_udr(udr1), .jdo(jdo1), .cmd_ir(cmdir1),
        .take_action(ta1), .take_no_action(tna1), .cmd_valid(cv1),
        .cmd_ready(rdy1), .ovr_clr(clr1), .overrun(ovr1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int unsigned c, input logic [63:0] d,
                                input logic [2:0] ir, input bit act);
        exp_t e;
        logic [7:0] oh;
        oh    = 8'd1 << ir;
        e.cyc = c;
        e.jdo = d;
        e.ir  = ir;
        e.ta  = act ? oh : 8'd0;
        e.tna = act ? 8'd0 : oh;
        return e;
    endfunction

    // Scoreboard: every cycle with a pulse must match the oldest expected command.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (|ta0 || |tna0) begin
            if (q0.size() == 0) chk("spurious_pulse0", {56'd0, ta0, tna0}, 64'd0);
            else begin
                e = q0.pop_front();
                chk("pulse_cycle0", 64'(cyc), 64'(e.cyc));
                chk("jdo0", 64'(jdo0), e.jdo);
                chk("cmd_ir0", 64'(cmdir0), 64'(e.ir));
                chk("take_action0", 64'(ta0), 64'(e.ta));
                chk("take_no_action0", 64'(tna0), 64'(e.tna));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (|ta1 || |tna1) begin
            if (q1.size() == 0) chk("spurious_pulse1", {48'd0, ta1, tna1}, 64'd0);
            else begin
                e = q1.pop_front();
                chk("pulse_cycle1", 64'(cyc), 64'(e.cyc));
                chk("jdo1", jdo1, e.jdo);
                chk("cmd_ir1", 64'(cmdir1), 64'(e.ir));
                chk("take_action1", 64'(ta1), 64'(e.ta));
                chk("take_no_action1", 64'(tna1), 64'(e.tna));
            end
        end
    end

    task automatic uir0_cmd(input logic [1:0] ir);
        @(negedge clk);
        ir0 = ir; uir0 = 1'b1;
        repeat (6) @(negedge clk);
        uir0 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic udr0_cmd(input logic [37:0] d, input logic [1:0] ir, input bit push);
        @(negedge clk);
        sr0 = d; udr0 = 1'b1;
        if (push) q0.push_back(mk(cyc + D0_SS + 1, 64'(d), 3'(ir), d[37]));
        repeat (6) @(negedge clk);
        udr0 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic uir1_cmd(input logic [2:0] ir);
        @(negedge clk);
        ir1 = ir; uir1 = 1'b1;
        repeat (7) @(negedge clk);
        uir1 = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic udr1_cmd(input logic [63:0] d, input logic [2:0] ir);
        @(negedge clk);
        sr1 = d; udr1 = 1'b1;
        q1.push_back(mk(cyc + D1_SS + 1, d, ir, d[63]));
        repeat (7) @(negedge clk);
        udr1 = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        ir0 = '0; sr0 = '0; uir0 = 1'b0; udr0 = 1'b0; rdy0 = 1'b1; clr0 = 1'b0;
        ir1 = '0; sr1 = '0; uir1 = 1'b0; udr1 = 1'b0; rdy1 = 1'b1; clr1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_jdo", 64'(jdo0), 64'd0);
        chk("rst_cmd_ir", 64'(cmdir0), 64'd0);
        chk("rst_take_action", 64'(ta0), 64'd0);
        chk("rst_take_no_action", 64'(tna0), 64'd0);
        chk("rst_cmd_valid", 64'(cv0), 64'd0);
        chk("rst_overrun", 64'(ovr0), 64'd0);
        chk("rst_jdo1", jdo1, 64'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // action and no-action on IR 1
        uir0_cmd(2'b01);
        udr0_cmd(38'h20_0000_1234, 2'b01, 1'b1);
        udr0_cmd(38'h00_0000_5678, 2'b01, 1'b1);
        uir0_cmd(2'b10);
        udr0_cmd(38'h3F_0F0F_0F0F, 2'b10, 1'b1);

        // simultaneous UIR/UDR rise decodes the new IR; later UDR reuses it
        uir0_cmd(2'b00);
        @(negedge clk);
        ir0 = 2'b11; sr0 = 38'h21_2345_6789; uir0 = 1'b1; udr0 = 1'b1;
        q0.push_back(mk(cyc + D0_SS + 1, 64'h21_2345_6789, 3'd3, 1'b1));
        repeat (6) @(negedge clk);
        uir0 = 1'b0; udr0 = 1'b0;
        repeat (6) @(negedge clk);
        udr0_cmd(38'h01_AAAA_5555, 2'b11, 1'b1);

        // asynchronous reset with vs_udr held high through release
        @(negedge clk);
        reset_n = 1'b0; udr0 = 1'b1; sr0 = 38'h3F_FFFF_0001;
        #1;
        chk("async_rst_jdo", 64'(jdo0), 64'd0);
        chk("async_rst_cmd_ir", 64'(cmdir0), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_high_no_pulse_jdo", 64'(jdo0), 64'd0);
        udr0 = 1'b0;
        repeat (6) @(negedge clk);
        udr0_cmd(38'h3F_FFFF_0001, 2'b00, 1'b1);

        rdy0 = 1'b0;
`ifdef JTAG_DBG_CMD_HS_EN
        udr0_cmd(38'h20_1111_AAAA, 2'b00, 1'b1);
        udr0_cmd(38'h00_2222_BBBB, 2'b00, 1'b0);
        chk("hs_jdo_held", 64'(jdo0), 64'h20_1111_AAAA);
        chk("hs_cmd_valid", 64'(cv0), 64'd1);
        chk("hs_overrun_set", 64'(ovr0), 64'd1);
        rdy0 = 1'b1;
        @(negedge clk);
        chk("hs_cmd_valid_drop", 64'(cv0), 64'd0);
        chk("hs_overrun_sticky", 64'(ovr0), 64'd1);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("hs_overrun_clear", 64'(ovr0), 64'd0);
`else
        udr0_cmd(38'h20_1111_AAAA, 2'b00, 1'b1);
        udr0_cmd(38'h00_2222_BBBB, 2'b00, 1'b1);
        chk("nohs_jdo_latest", 64'(jdo0), 64'h00_2222_BBBB);
        chk("nohs_cmd_valid", 64'(cv0), 64'd0);
        chk("nohs_overrun", 64'(ovr0), 64'd0);
        rdy0 = 1'b1;
`endif

        // wide instance, three synchronizer stages
        uir1_cmd(3'd5);
        udr1_cmd(64'h8000_0000_DEAD_BEEF, 3'd5);
        udr1_cmd(64'h7FFF_FFFF_0000_0001, 3'd5);
        uir1_cmd(3'd7);
        udr1_cmd(64'hFFFF_FFFF_FFFF_FFFF, 3'd7);

        repeat (8) @(negedge clk);
        chk("pending0", 64'(q0.size()), 64'd0);
        chk("pending1", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
